// File: rtl/sram_ctrl.sv
// Synchronous initiator for an async SRAM port: one request per handshake, registered strobes.
// Define SRAM_CTRL_WR_VERIFY_EN to add an automatic read-back after each write (sticky wr_err on mismatch).
//
// state   | meaning
// IDLE    | waiting for a request, req_ready high
// SETUP   | address (and write data) presented, strobes high
// PULSE   | selected strobe low
// HOLD    | strobes high, address (and write data) held
// VSETUP  | verify read-back setup (write-verify build only)
// VPULSE  | verify read-back, mem_oe low
// VHOLD   | verify read-back hold
module sram_ctrl #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              wr_err,
    output logic              mem_oe,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    inout  wire  [DATA_W-1:0] mem_data
);

    localparam int CNT_MAX_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int CNT_MAX    = (CNT_MAX_SP > HOLD_CYC) ? CNT_MAX_SP : HOLD_CYC;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_VSETUP, S_VPULSE, S_VHOLD
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               we_q, we_nxt;
    logic [DATA_W-1:0]  wdata_q;
    logic               drive_en, drive_nxt;
    logic               accept;
    logic               last_pulse;
    logic               oe_nxt, we_strobe_nxt;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        accept        = (state == S_IDLE) && req_valid && req_ready;
        last_pulse    = (state == S_PULSE) && (cnt == '0);
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_SETUP;
                    cnt_nxt   = SETUP_LD;
                end
            end
            S_SETUP: begin
                if (cnt == '0) begin
                    state_nxt = S_PULSE;
                    cnt_nxt   = PULSE_LD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_PULSE: begin
                if (cnt == '0) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = HOLD_LD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt == '0) begin
`ifdef SRAM_CTRL_WR_VERIFY_EN
                    if (we_q) begin
                        state_nxt = S_VSETUP;
                        cnt_nxt   = SETUP_LD;
                    end else begin
                        state_nxt = S_IDLE;
                    end
`else
                    state_nxt = S_IDLE;
`endif
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_VSETUP: begin
                if (cnt == '0) begin
                    state_nxt = S_VPULSE;
                    cnt_nxt   = PULSE_LD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_VPULSE: begin
                if (cnt == '0) begin
                    state_nxt = S_VHOLD;
                    cnt_nxt   = HOLD_LD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_VHOLD: begin
                if (cnt == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Outputs are decoded from the next state so strobes and bus enable leave flops directly.
        we_nxt        = accept ? req_we : we_q;
        oe_nxt        = !(((state_nxt == S_PULSE) && !we_nxt) || (state_nxt == S_VPULSE));
        we_strobe_nxt = !((state_nxt == S_PULSE) && we_nxt);
        drive_nxt     = we_nxt && ((state_nxt == S_SETUP) || (state_nxt == S_PULSE) ||
                                   (state_nxt == S_HOLD));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            req_ready <= 1'b0;
            mem_oe    <= 1'b1;
            mem_we    <= 1'b1;
            drive_en  <= 1'b0;
            we_q      <= 1'b0;
            mem_addr  <= '0;
            wdata_q   <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            req_ready <= (state_nxt == S_IDLE);
            mem_oe    <= oe_nxt;
            mem_we    <= we_strobe_nxt;
            drive_en  <= drive_nxt;
            if (accept) begin
                we_q     <= req_we;
                mem_addr <= req_addr;
                wdata_q  <= req_wdata;
            end
            rd_valid <= last_pulse && !we_q;
            if (last_pulse && !we_q) begin
                rd_data <= mem_data;
            end
        end
    end

    assign mem_data = drive_en ? wdata_q : {DATA_W{1'bz}};

`ifdef SRAM_CTRL_WR_VERIFY_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_err <= 1'b0;
        end else if ((state == S_VPULSE) && (cnt == '0) && (mem_data != wdata_q)) begin
            wr_err <= 1'b1;
        end
    end
`else
    assign wr_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a behavioural async SRAM on the shared bus.
// Build with SRAM_CTRL_WR_VERIFY_EN defined to exercise the write-verify variant.
module tb_sram_ctrl;

`ifdef SRAM_CTRL_WR_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    localparam int WOCC = VERIFY ? 8 : 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        wr_err;
    logic        mem_oe;
    logic        mem_we;
    logic [15:0] mem_addr;
    wire  [15:0] mem_data;

    logic [15:0] mem [0:65535];
    logic [15:0] sram_q;
    logic [15:0] corrupt;

    int passed = 0;
    int total  = 0;

    logic [8:0] exp_we_w;
    logic [8:0] exp_oe_w;

    always #5 clk = ~clk;

    sram_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .wr_err    (wr_err),
        .mem_oe    (mem_oe),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data)
    );

    // Behavioural SRAM: drives the bus while mem_oe is low, stores on edges where mem_we is low.
    assign mem_data = (mem_oe == 1'b0) ? (sram_q ^ corrupt) : 16'hzzzz;

    always @(negedge clk) sram_q <= mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we == 1'b0) mem[mem_addr] <= mem_data;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {31'd0, req_ready}, 32'd1);
    endtask

    // Presents a request on an IDLE cycle; returns at the negedge of the first SETUP cycle.
    task automatic issue(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                         input bit hold);
        wait_ready();
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic check_write(input string tag, input logic [15:0] addr, input logic [15:0] wdata);
        for (int k = 0; k <= WOCC; k++) begin
            chk($sformatf("%s_we[%0d]", tag, k), {31'd0, mem_we}, {31'd0, exp_we_w[k]});
            chk($sformatf("%s_oe[%0d]", tag, k), {31'd0, mem_oe}, {31'd0, exp_oe_w[k]});
            chk($sformatf("%s_rdy[%0d]", tag, k), {31'd0, req_ready}, (k == WOCC) ? 32'd1 : 32'd0);
            chk($sformatf("%s_rv[%0d]", tag, k), {31'd0, rd_valid}, 32'd0);
            if (k <= 3) begin
                chk($sformatf("%s_addr[%0d]", tag, k), {16'd0, mem_addr}, {16'd0, addr});
                chk($sformatf("%s_data[%0d]", tag, k), {16'd0, mem_data}, {16'd0, wdata});
            end
            if (k < WOCC) @(negedge clk);
        end
    endtask

    task automatic check_read(input string tag, input logic [15:0] addr, input logic [15:0] data);
        for (int k = 0; k <= 4; k++) begin
            chk($sformatf("%s_oe[%0d]", tag, k), {31'd0, mem_oe}, (k == 1 || k == 2) ? 32'd0 : 32'd1);
            chk($sformatf("%s_we[%0d]", tag, k), {31'd0, mem_we}, 32'd1);
            chk($sformatf("%s_rdy[%0d]", tag, k), {31'd0, req_ready}, (k == 4) ? 32'd1 : 32'd0);
            chk($sformatf("%s_rv[%0d]", tag, k), {31'd0, rd_valid}, (k == 3) ? 32'd1 : 32'd0);
            if (k <= 3) chk($sformatf("%s_addr[%0d]", tag, k), {16'd0, mem_addr}, {16'd0, addr});
            if (k == 3) chk($sformatf("%s_rdata", tag), {16'd0, rd_data}, {16'd0, data});
            if (k < 4) @(negedge clk);
        end
    endtask

    initial begin
        exp_we_w  = 9'b111111001;
        exp_oe_w  = VERIFY ? 9'b110011111 : 9'b111111111;
        reset     = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 16'h0000;
        req_wdata = 16'h0000;
        corrupt   = 16'h0000;

        // Reset held three cycles with a pending request.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_oe", {31'd0, mem_oe}, 32'd1);
            chk("rst_we", {31'd0, mem_we}, 32'd1);
            chk("rst_rdy", {31'd0, req_ready}, 32'd0);
            chk("rst_rv", {31'd0, rd_valid}, 32'd0);
            chk("rst_rdata", {16'd0, rd_data}, 32'd0);
            chk("rst_err", {31'd0, wr_err}, 32'd0);
            chk("rst_addr", {16'd0, mem_addr}, 32'd0);
        end
        req_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        chk("rel_rdy", {31'd0, req_ready}, 32'd1);

        // Single write then read-back of the same location.
        issue(1'b1, 16'h0010, 16'h1234, 1'b0);
        check_write("wr1", 16'h0010, 16'h1234);
        issue(1'b0, 16'h0010, 16'h0000, 1'b0);
        check_read("rd1", 16'h0010, 16'h1234);

        // Back-to-back write then read at the top address with req_valid held high.
        issue(1'b1, 16'hFFFF, 16'hBEEF, 1'b1);
        req_we    = 1'b0;
        req_wdata = 16'h0000;
        for (int k = 0; k <= WOCC + 5; k++) begin
            int kr;
            kr = k - WOCC - 1;
            chk($sformatf("b2b_excl[%0d]", k), {31'd0, mem_oe | mem_we}, 32'd1);
            chk($sformatf("b2b_rdy[%0d]", k), {31'd0, req_ready},
                (k == WOCC || k == WOCC + 5) ? 32'd1 : 32'd0);
            if (k <= 3) chk($sformatf("b2b_wdata[%0d]", k), {16'd0, mem_data}, 32'h0000BEEF);
            if (k == WOCC || k == WOCC + 1) begin
                chk($sformatf("b2b_turn_oe[%0d]", k), {31'd0, mem_oe}, 32'd1);
                chk($sformatf("b2b_turn_we[%0d]", k), {31'd0, mem_we}, 32'd1);
            end
            if (kr >= 0) begin
                chk($sformatf("b2b_roe[%0d]", kr), {31'd0, mem_oe}, (kr == 1 || kr == 2) ? 32'd0 : 32'd1);
                chk($sformatf("b2b_rv[%0d]", kr), {31'd0, rd_valid}, (kr == 3) ? 32'd1 : 32'd0);
            end else begin
                chk($sformatf("b2b_wrv[%0d]", k), {31'd0, rd_valid}, 32'd0);
            end
            if (kr == 0) chk("b2b_raddr", {16'd0, mem_addr}, 32'h0000FFFF);
            if (kr == 3) chk("b2b_rdata", {16'd0, rd_data}, 32'h0000BEEF);
            if (k == WOCC + 1) req_valid = 1'b0;
            if (k < WOCC + 5) @(negedge clk);
        end

        // Reset asserted during the second PULSE cycle of a read.
        issue(1'b0, 16'h0010, 16'h0000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_pulse2_oe", {31'd0, mem_oe}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_oe", {31'd0, mem_oe}, 32'd1);
        chk("abort_rv", {31'd0, rd_valid}, 32'd0);
        chk("abort_rdata", {16'd0, rd_data}, 32'd0);
        chk("abort_rdy", {31'd0, req_ready}, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("abort_post_rv[%0d]", i), {31'd0, rd_valid}, 32'd0);
            chk($sformatf("abort_post_rdy[%0d]", i), {31'd0, req_ready}, 32'd1);
        end

        // Corrupted verify read, then a clean write; wr_err must be sticky in the verify build.
        corrupt = 16'h0001;
        issue(1'b1, 16'h0020, 16'h5A5A, 1'b0);
        check_write("wrc", 16'h0020, 16'h5A5A);
        corrupt = 16'h0000;
        chk("err_set", {31'd0, wr_err}, VERIFY ? 32'd1 : 32'd0);
        issue(1'b1, 16'h0022, 16'h0F0F, 1'b0);
        check_write("wr2", 16'h0022, 16'h0F0F);
        chk("err_sticky", {31'd0, wr_err}, VERIFY ? 32'd1 : 32'd0);
        issue(1'b0, 16'h0022, 16'h0000, 1'b0);
        check_read("rd2", 16'h0022, 16'h0F0F);
        chk("err_final", {31'd0, wr_err}, VERIFY ? 32'd1 : 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
